// File: rtl/compar_pkg.sv
// -----------------------------------------------------------------------------
// compar_pkg
// Shared types and constants for the magnitude comparator.
//   cmp_res_t  : encoded relation of A to B (NONE only before the first capture)
//   CMP_W_MAX  : widest operand the comparator supports
// -----------------------------------------------------------------------------
package compar_pkg;

  localparam int CMP_W_MAX = 16;

  typedef enum logic [1:0] {
    CMP_NONE = 2'd0,
    CMP_LT   = 2'd1,
    CMP_EQ   = 2'd2,
    CMP_GT   = 2'd3
  } cmp_res_t;

endpackage : compar_pkg

// File: rtl/compar_cell.sv
// -----------------------------------------------------------------------------
// compar_cell
// Purely combinational WIDTH-bit magnitude compare of A against B.
// Ports:
//   A, B : operands (unsigned, or two's complement when SIGNED_CMP=1)
//   res  : CMP_GT / CMP_EQ / CMP_LT (never CMP_NONE)
// -----------------------------------------------------------------------------
module compar_cell
  import compar_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output cmp_res_t         res
);

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order (most negative becomes 0), so one cascade serves both modes.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    SIGNED_CMP ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;
  logic             gt_acc;
  logic             eq_acc;

  assign a_k = A ^ SIGN_MASK;
  assign b_k = B ^ SIGN_MASK;

  // MSB-first cascade: a bit position decides "greater" only while every
  // more significant bit pair has been equal so far.
  always_comb begin
    gt_acc = 1'b0;
    eq_acc = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gt_acc = gt_acc | (eq_acc & a_k[i] & ~b_k[i]);
      eq_acc = eq_acc & ~(a_k[i] ^ b_k[i]);
    end
    if (gt_acc)      res = CMP_GT;
    else if (eq_acc) res = CMP_EQ;
    else             res = CMP_LT;
  end

endmodule : compar_cell

// File: rtl/mag_compar_2b.sv
// -----------------------------------------------------------------------------
// mag_compar_2b
// Registered magnitude comparator with a valid qualifier, one-cycle latency.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, clears all outputs
//   in_valid   : A/B sampled on this rising edge
//   A, B       : WIDTH-bit operands
//   out_valid  : flags reflect the pair accepted on the previous edge
//   A_gt_B, A_eq_B, A_lt_B : one-hot relation flags (all 0 before first capture)
//
// Handshake: valid-only, no backpressure. Every edge with in_valid=1 accepts a
// pair, and out_valid is high for exactly the following cycle per pair. On an
// edge with in_valid=0 out_valid drops and the flags hold their last value.
// -----------------------------------------------------------------------------
module mag_compar_2b
  import compar_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             A_gt_B,
  output logic             A_eq_B,
  output logic             A_lt_B
);

  if (WIDTH < 1 || WIDTH > CMP_W_MAX) begin : g_width_err
    $error("mag_compar_2b: WIDTH must be in 1..%0d", CMP_W_MAX);
  end

  cmp_res_t cell_res;
  cmp_res_t res_q;
  logic     valid_q;

  compar_cell #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cell (
    .A   (A),
    .B   (B),
    .res (cell_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= CMP_NONE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) res_q <= cell_res;
    end
  end

  // Decode of registered state only: no input-to-output combinational path.
  assign out_valid = valid_q;
  assign A_gt_B    = (res_q == CMP_GT);
  assign A_eq_B    = (res_q == CMP_EQ);
  assign A_lt_B    = (res_q == CMP_LT);

  a_onehot : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot({A_gt_B, A_eq_B, A_lt_B}));

  a_known_in : assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown({A, B}));

endmodule : mag_compar_2b

// File: tb/tb_mag_compar_2b.sv
// -----------------------------------------------------------------------------
// tb_mag_compar_2b
// Drives an unsigned and a signed WIDTH=2 comparator from the same stimulus
// and checks both against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mag_compar_2b;

  localparam int W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic u_valid, u_gt, u_eq, u_lt;
  logic s_valid, s_gt, s_eq, s_lt;
  logic [2:0] u_flags, s_flags;
  assign u_flags = {u_gt, u_eq, u_lt};
  assign s_flags = {s_gt, s_eq, s_lt};

  mag_compar_2b #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(u_valid), .A_gt_B(u_gt), .A_eq_B(u_eq), .A_lt_B(u_lt)
  );

  mag_compar_2b #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(s_valid), .A_gt_B(s_gt), .A_eq_B(s_eq), .A_lt_B(s_lt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];        // {unsigned flags, signed flags}
  logic [5:0] last_exp = '0;   // flags held since last capture

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer comparison, {gt,eq,lt}.
  function automatic logic [2:0] ref_flags(input int a, input int b, input bit sgn);
    int av, bv;
    av = a;
    bv = b;
    if (sgn && av >= (1 << (W - 1))) av = av - (1 << W);
    if (sgn && bv >= (1 << (W - 1))) bv = bv - (1 << W);
    if (av > bv)       return 3'b100;
    else if (av == bv) return 3'b010;
    else               return 3'b001;
  endfunction

  // ---------------- driver ----------------
  // Apply one cycle of stimulus at the falling edge, then check just after
  // the following rising edge.
  task automatic drive(input string tag, input bit iv, input int a, input int b);
    @(negedge clk);
    in_valid = iv;
    A = W'(a);
    B = W'(b);
    if (iv) exp_q.push_back({ref_flags(a, b, 1'b0), ref_flags(a, b, 1'b1)});
    @(posedge clk);
    #1;
    if (iv) begin
      if (exp_q.size() == 0) check({tag, "_qempty"}, 1, 0);
      else last_exp = exp_q.pop_front();
    end
    check({tag, "_u_valid"}, 32'(u_valid), 32'(iv));
    check({tag, "_s_valid"}, 32'(s_valid), 32'(iv));
    check({tag, "_u_flags"}, 32'(u_flags), 32'(last_exp[5:3]));
    check({tag, "_s_flags"}, 32'(s_flags), 32'(last_exp[2:0]));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_u_valid"}, 32'(u_valid), 0);
    check({tag, "_s_valid"}, 32'(s_valid), 0);
    check({tag, "_u_flags"}, 32'(u_flags), 0);
    check({tag, "_s_flags"}, 32'(s_flags), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held 3 cycles with live inputs: outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A = W'($urandom_range(0, 3));
      B = W'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      check_cleared("rst_hold");
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    last_exp = '0;

    // Idle after reset: flags still all zero.
    drive("post_rst_idle", 1'b0, 0, 0);

    // Exhaustive, back-to-back.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        drive("exh", 1'b1, a, b);

    // Back-to-back sequence eq, lt, gt.
    drive("b2b_eq", 1'b1, 3, 3);
    drive("b2b_lt", 1'b1, 1, 2);
    drive("b2b_gt", 1'b1, 2, 1);

    // Idle hold after one capture of (0,0).
    drive("hold_cap", 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) drive("hold_idle", 1'b0, 1, 2);

    // Signed-specific pairs (checked on both instances).
    drive("sgn_10_01", 1'b1, 2, 1);
    drive("sgn_11_10", 1'b1, 3, 2);
    drive("sgn_11_11", 1'b1, 3, 3);

    // Random mix of captures and idles.
    for (int i = 0; i < 60; i++)
      drive("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Reset mid-stream: asynchronous clear before the next edge.
    drive("mid_cap", 1'b1, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("async_rst_edge");
    @(negedge clk);
    rst = 1'b0;
    last_exp = '0;
    @(posedge clk);
    #1;
    check_cleared("post_rst_drop");

    // Recovery capture after reset.
    drive("recover", 1'b1, 3, 0);
    drive("recover2", 1'b1, 0, 3);

    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mag_compar_2b
